// File: rtl/sddt_debug_monitor_pkg.sv
// Shared helpers for the SDDT debug monitor: trace entry sizing, popcount, and
// the wrap/clamp counter add.
package sddt_dbg_pkg;

  // Widest per-slot command vector the popcount helper accepts.
  localparam int POP_MAX_W = 32;

  // Accumulator width for counter additions. This is a superset of the
  // CNT_W+$clog2(NUM_SLOTS)+1 bits that a single add can occupy.
  localparam int ACC_W = 64;

  // Trace entry layout, MSB first: {timestamp, ddr_pre, ddr_nop}.
  function automatic int trace_entry_w(int cnt_w, int num_slots);
    return cnt_w + 2 * num_slots;
  endfunction

  // Number of set bits in a zero-extended command vector.
  function automatic int unsigned popcount(logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n += {31'b0, v[i]};
    end
    return n;
  endfunction

  // Adds inc to cur in the wide accumulator. The result then either wraps
  // modulo 2^cnt_w or clamps at all-ones.
  function automatic logic [ACC_W-1:0] cnt_add(logic [ACC_W-1:0] cur,
                                                logic [ACC_W-1:0] inc,
                                                int               cnt_w,
                                                bit               sat);
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] lim;
    lim = (ACC_W'(1) << cnt_w) - ACC_W'(1);
    sum = cur + inc;
    if (sat && (sum > lim)) begin
      return lim;
    end
    return sum & lim;
  endfunction

endpackage

// File: rtl/sddt_debug_monitor_if.sv
// Tap bundle between the SDDT datapath and the debug monitor.
// It carries the stream/PHY/command taps in, and the trace FIFO drain port.
interface sddt_debug_monitor_if
  import sddt_dbg_pkg::*;
#(
  parameter int NUM_SLOTS   = 4,
  parameter int CNT_W       = 16,
  parameter int TAP_W       = 8,
  parameter int TRACE_DEPTH = 16
);
  localparam int TW    = trace_entry_w(CNT_W, NUM_SLOTS);
  localparam int LVL_W = $clog2(TRACE_DEPTH) + 1;

  logic                 axis_tvalid;
  logic                 axis_tready;
  logic [TAP_W-1:0]     axis_tdata_tap;
  logic                 rd_data_en;
  logic                 err_in;
  logic [NUM_SLOTS-1:0] ddr_read;
  logic [NUM_SLOTS-1:0] ddr_write;
  logic [NUM_SLOTS-1:0] ddr_pre;
  logic [NUM_SLOTS-1:0] ddr_nop;
  logic                 trace_pop;
  logic                 trace_valid;
  logic [TW-1:0]        trace_data;
  logic [LVL_W-1:0]     trace_level;
  logic                 trace_overflow;

  // Datapath/host side: drives the taps and the pop strobe.
  modport master (
    output axis_tvalid, axis_tready, axis_tdata_tap, rd_data_en, err_in,
    output ddr_read, ddr_write, ddr_pre, ddr_nop, trace_pop,
    input  trace_valid, trace_data, trace_level, trace_overflow
  );

  // Monitor side.
  modport slave (
    input  axis_tvalid, axis_tready, axis_tdata_tap, rd_data_en, err_in,
    input  ddr_read, ddr_write, ddr_pre, ddr_nop, trace_pop,
    output trace_valid, trace_data, trace_level, trace_overflow
  );

endinterface

// File: rtl/sddt_debug_monitor_trace_fifo.sv
// First-word-fall-through synchronous FIFO for command trace entries.
// A push while full is dropped and latches a sticky drop flag, unless a pop
// frees the slot in the same cycle.
module sddt_trace_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign valid   = (level != '0);
  assign pop_ok  = pop & valid;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  // Storage: data only, no reset needed since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and sticky drop flag. Pointers wrap as DEPTH is 2^AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/sddt_debug_monitor.sv
// SDDT debug/performance monitor. It keeps event counters, sticky error
// tracking, a coherent one-edge snapshot, and a timestamped trace of
// non-NOP command cycles.
module sddt_debug_monitor
  import sddt_dbg_pkg::*;
#(
  parameter int NUM_SLOTS   = 4,
  parameter int CNT_W       = 16,
  parameter int TAP_W       = 8,
  parameter int TRACE_DEPTH = 16,
  parameter int SATURATE    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 snap_req,
  sddt_debug_monitor_if.slave  mon,
  output logic [CNT_W-1:0]     snap_hs_cnt,
  output logic [CNT_W-1:0]     snap_rden_cnt,
  output logic [CNT_W-1:0]     snap_rdcmd_cnt,
  output logic [CNT_W-1:0]     snap_wrcmd_cnt,
  output logic [TAP_W-1:0]     latest_hs_data,
  output logic                 err_sticky
);
  localparam int TW     = trace_entry_w(CNT_W, NUM_SLOTS);
  localparam bit SAT_EN = (SATURATE != 0);

  logic [CNT_W-1:0] hs_cnt, rden_cnt, rdcmd_cnt, wrcmd_cnt;
  logic [CNT_W-1:0] hs_nxt, rden_nxt, rdcmd_nxt, wrcmd_nxt;
  logic [CNT_W-1:0] timestamp;
  logic             hs;
  logic             wipe;
  logic             trace_push;
  logic [TW-1:0]    trace_entry;

  assign hs          = mon.axis_tvalid & mon.axis_tready;
  assign wipe        = rst | clr;
  assign trace_push  = ~&mon.ddr_nop;
  assign trace_entry = {timestamp, mon.ddr_pre, mon.ddr_nop};

  // Post-update counter values. Snapshots load these, so they include this cycle's events.
  always_comb begin
    hs_nxt    = CNT_W'(cnt_add(ACC_W'(hs_cnt), ACC_W'(hs), CNT_W, SAT_EN));
    rden_nxt  = CNT_W'(cnt_add(ACC_W'(rden_cnt), ACC_W'(mon.rd_data_en), CNT_W, SAT_EN));
    rdcmd_nxt = CNT_W'(cnt_add(ACC_W'(rdcmd_cnt),
                               ACC_W'(popcount(POP_MAX_W'(mon.ddr_read))), CNT_W, SAT_EN));
    wrcmd_nxt = CNT_W'(cnt_add(ACC_W'(wrcmd_cnt),
                               ACC_W'(popcount(POP_MAX_W'(mon.ddr_write))), CNT_W, SAT_EN));
  end

  // Live counters, timestamp, handshake tap, sticky error and snapshot bank.
  // Soft clear discards same-cycle events.
  always_ff @(posedge clk) begin
    if (wipe) begin
      hs_cnt         <= '0;
      rden_cnt       <= '0;
      rdcmd_cnt      <= '0;
      wrcmd_cnt      <= '0;
      timestamp      <= '0;
      latest_hs_data <= '0;
      err_sticky     <= 1'b0;
      snap_hs_cnt    <= '0;
      snap_rden_cnt  <= '0;
      snap_rdcmd_cnt <= '0;
      snap_wrcmd_cnt <= '0;
    end else begin
      hs_cnt    <= hs_nxt;
      rden_cnt  <= rden_nxt;
      rdcmd_cnt <= rdcmd_nxt;
      wrcmd_cnt <= wrcmd_nxt;
      timestamp <= timestamp + 1'b1;
      if (hs)         latest_hs_data <= mon.axis_tdata_tap;
      if (mon.err_in) err_sticky     <= 1'b1;
      if (snap_req) begin
        snap_hs_cnt    <= hs_nxt;
        snap_rden_cnt  <= rden_nxt;
        snap_rdcmd_cnt <= rdcmd_nxt;
        snap_wrcmd_cnt <= wrcmd_nxt;
      end
    end
  end

  // Trace FIFO. A wipe also clears it, so a push or pop in a clear cycle is discarded.
  sddt_trace_fifo #(
    .W     (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .rst       (wipe),
    .push      (trace_push),
    .push_data (trace_entry),
    .pop       (mon.trace_pop),
    .valid     (mon.trace_valid),
    .head      (mon.trace_data),
    .level     (mon.trace_level),
    .overflow  (mon.trace_overflow)
  );

endmodule

// File: tb/tb_sddt_debug_monitor.sv
// Scoreboard bench for sddt_debug_monitor.
// A main DUT uses a 4-deep trace FIFO. Two 4-bit-counter DUTs, one
// saturating and one wrapping, share the same stimulus.
module tb_sddt_debug_monitor;
  import sddt_dbg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, clr = 1'b0, snap_req = 1'b0;
  logic       tv = 1'b0, tr = 1'b0, rde = 1'b0, err = 1'b0, pop = 1'b0;
  logic [7:0] td = '0;
  logic [3:0] rd = '0, wr = '0, pre = '0, nop = 4'hF;

  int n_vec = 0;
  int n_bad = 0;

  sddt_debug_monitor_if #(.NUM_SLOTS(4), .CNT_W(16), .TAP_W(8), .TRACE_DEPTH(4)) if0 ();
  sddt_debug_monitor_if #(.NUM_SLOTS(4), .CNT_W(4),  .TAP_W(8), .TRACE_DEPTH(16)) if1 ();
  sddt_debug_monitor_if #(.NUM_SLOTS(4), .CNT_W(4),  .TAP_W(8), .TRACE_DEPTH(16)) if2 ();

  assign if0.axis_tvalid = tv;  assign if1.axis_tvalid = tv;  assign if2.axis_tvalid = tv;
  assign if0.axis_tready = tr;  assign if1.axis_tready = tr;  assign if2.axis_tready = tr;
  assign if0.axis_tdata_tap = td; assign if1.axis_tdata_tap = td; assign if2.axis_tdata_tap = td;
  assign if0.rd_data_en = rde;  assign if1.rd_data_en = rde;  assign if2.rd_data_en = rde;
  assign if0.err_in = err;      assign if1.err_in = err;      assign if2.err_in = err;
  assign if0.ddr_read = rd;     assign if1.ddr_read = rd;     assign if2.ddr_read = rd;
  assign if0.ddr_write = wr;    assign if1.ddr_write = wr;    assign if2.ddr_write = wr;
  assign if0.ddr_pre = pre;     assign if1.ddr_pre = pre;     assign if2.ddr_pre = pre;
  assign if0.ddr_nop = nop;     assign if1.ddr_nop = nop;     assign if2.ddr_nop = nop;
  assign if0.trace_pop = pop;   assign if1.trace_pop = pop;   assign if2.trace_pop = pop;

  logic [15:0] s0_hs, s0_rden, s0_rd, s0_wr;
  logic [7:0]  s0_lat;
  logic        s0_err;
  logic [3:0]  s1_hs, s1_rden, s1_rd, s1_wr, s2_hs, s2_rden, s2_rd, s2_wr;
  logic [7:0]  s1_lat, s2_lat;
  logic        s1_err, s2_err;

  sddt_debug_monitor #(.NUM_SLOTS(4), .CNT_W(16), .TAP_W(8), .TRACE_DEPTH(4), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .snap_req(snap_req), .mon(if0),
    .snap_hs_cnt(s0_hs), .snap_rden_cnt(s0_rden), .snap_rdcmd_cnt(s0_rd),
    .snap_wrcmd_cnt(s0_wr), .latest_hs_data(s0_lat), .err_sticky(s0_err));

  sddt_debug_monitor #(.NUM_SLOTS(4), .CNT_W(4), .TAP_W(8), .TRACE_DEPTH(16), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .snap_req(snap_req), .mon(if1),
    .snap_hs_cnt(s1_hs), .snap_rden_cnt(s1_rden), .snap_rdcmd_cnt(s1_rd),
    .snap_wrcmd_cnt(s1_wr), .latest_hs_data(s1_lat), .err_sticky(s1_err));

  sddt_debug_monitor #(.NUM_SLOTS(4), .CNT_W(4), .TAP_W(8), .TRACE_DEPTH(16), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .clr(clr), .snap_req(snap_req), .mon(if2),
    .snap_hs_cnt(s2_hs), .snap_rden_cnt(s2_rden), .snap_rdcmd_cnt(s2_rd),
    .snap_wrcmd_cnt(s2_wr), .latest_hs_data(s2_lat), .err_sticky(s2_err));

  typedef struct {
    logic [15:0] hs, rden, rd, wr;
    logic [7:0]  lat;
    logic [3:0]  rden_sat, rden_wrap;
  } snap_t;

  snap_t       snap_q[$];
  logic [23:0] trace_q[$];
  logic        snap_seen = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: a snapshot is presented on the edge after snap_req; a trace entry
  // is presented whenever the host pops a valid head.
  always @(posedge clk) snap_seen <= snap_req;

  always @(negedge clk) begin
    if (snap_seen) begin
      if (snap_q.size() == 0) cmp("snap_unexpected", 32'd1, 32'd0);
      else begin
        snap_t e;
        e = snap_q.pop_front();
        cmp("snap_hs",        32'(s0_hs),   32'(e.hs));
        cmp("snap_rden",      32'(s0_rden), 32'(e.rden));
        cmp("snap_rdcmd",     32'(s0_rd),   32'(e.rd));
        cmp("snap_wrcmd",     32'(s0_wr),   32'(e.wr));
        cmp("latest_hs_data", 32'(s0_lat),  32'(e.lat));
        cmp("snap_rden_sat",  32'(s1_rden), 32'(e.rden_sat));
        cmp("snap_rden_wrap", 32'(s2_rden), 32'(e.rden_wrap));
      end
    end
    if (if0.trace_valid && pop) begin
      if (trace_q.size() == 0) cmp("trace_unexpected", 32'd1, 32'd0);
      else cmp("trace_data", 32'(if0.trace_data), 32'(trace_q.pop_front()));
    end
  end

  task automatic idle();
    clr = 0; snap_req = 0; tv = 0; tr = 0; td = 8'h00; rde = 0; err = 0;
    rd = '0; wr = '0; pre = '0; nop = 4'hF; pop = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input snap_t e);
    snap_req = 1'b1;
    snap_q.push_back(e);
    step();
    snap_req = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Reset state
    cmp("rst_snap_hs",  32'(s0_hs), 0);
    cmp("rst_latest",   32'(s0_lat), 0);
    cmp("rst_err",      32'(s0_err), 0);
    cmp("rst_tvalid",   32'(if0.trace_valid), 0);
    cmp("rst_level",    32'(if0.trace_level), 0);
    cmp("rst_overflow", 32'(if0.trace_overflow), 0);

    // 1: five handshakes interleaved with tvalid-only cycles
    for (int i = 0; i < 5; i++) begin
      tv = 1; tr = 1; td = 8'h11 + 8'(i);
      step();
      if (i < 3) begin
        tv = 1; tr = 0; td = 8'hEE;
        step();
      end
    end
    idle();
    snap('{hs:16'd5, rden:16'd0, rd:16'd0, wr:16'd0, lat:8'h15, rden_sat:4'd0, rden_wrap:4'd0});

    // 2: READ popcounts 3+3+3+4, then a snapshot coinciding with one more READ
    for (int i = 0; i < 4; i++) begin
      rd = (i < 3) ? 4'b1011 : 4'b1111;
      wr = 4'b0001;
      step();
    end
    idle();
    snap('{hs:16'd5, rden:16'd0, rd:16'd13, wr:16'd4, lat:8'h15, rden_sat:4'd0, rden_wrap:4'd0});
    rd = 4'b0001;
    snap('{hs:16'd5, rden:16'd0, rd:16'd14, wr:16'd4, lat:8'h15, rden_sat:4'd0, rden_wrap:4'd0});
    idle();

    // 3: 20 read-enable pulses (16-bit: 20, 4-bit clamp: 15, 4-bit wrap: 4)
    rde = 1;
    repeat (20) step();
    idle();
    snap('{hs:16'd5, rden:16'd20, rd:16'd14, wr:16'd4, lat:8'h15, rden_sat:4'd15, rden_wrap:4'd4});

    // 4: six pushes into a 4-deep FIFO, then drain in order
    clr = 1; step(); idle();
    for (int i = 0; i < 6; i++) begin
      pre = 4'hA ^ 4'(i); nop = 4'(i);
      step();
    end
    idle();
    cmp("ovf_level",    32'(if0.trace_level), 4);
    cmp("ovf_flag",     32'(if0.trace_overflow), 1);
    cmp("ovf_head",     32'(if0.trace_data), 32'h0000A0);
    trace_q.push_back(24'h0000A0);
    trace_q.push_back(24'h0001B1);
    trace_q.push_back(24'h000282);
    trace_q.push_back(24'h000393);
    pop = 1;
    repeat (4) step();
    pop = 0;
    cmp("drain_valid",  32'(if0.trace_valid), 0);
    cmp("drain_level",  32'(if0.trace_level), 0);
    cmp("drain_ovf",    32'(if0.trace_overflow), 1);

    // 5: full FIFO with simultaneous push and pop
    clr = 1; step(); idle();
    for (int i = 0; i < 4; i++) begin
      pre = 4'h0; nop = 4'h1;
      step();
    end
    cmp("full_level",   32'(if0.trace_level), 4);
    cmp("full_ovf",     32'(if0.trace_overflow), 0);
    pop = 1;
    trace_q.push_back(24'h000001);
    step();
    idle();
    cmp("pp_level",     32'(if0.trace_level), 4);
    cmp("pp_ovf",       32'(if0.trace_overflow), 0);
    cmp("pp_head",      32'(if0.trace_data), 32'h000101);

    // 6: sticky error, then clear coinciding with a handshake
    err = 1; step(); idle();
    cmp("err_set",      32'(s0_err), 1);
    clr = 1; tv = 1; tr = 1; td = 8'h77;
    step();
    idle();
    cmp("clr_err",      32'(s0_err), 0);
    cmp("clr_valid",    32'(if0.trace_valid), 0);
    cmp("clr_level",    32'(if0.trace_level), 0);
    cmp("clr_ovf",      32'(if0.trace_overflow), 0);
    cmp("clr_snap_rd",  32'(s0_rd), 0);
    snap('{hs:16'd0, rden:16'd0, rd:16'd0, wr:16'd0, lat:8'h00, rden_sat:4'd0, rden_wrap:4'd0});

    repeat (2) step();
    cmp("snap_q_empty",  32'(snap_q.size()), 0);
    cmp("trace_q_empty", 32'(trace_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sddt_debug_monitor.md
Name: sddt_debug_monitor

Overview:
Parametrised debug and performance monitor for the SDDT datapath. It sits beside sddt_core in the c0_ddr4_clk domain and taps the following:
- the C2H AXI-Stream handshake
- PHY read-data enables
- the per-slot DDR command vectors

It keeps event counters, sticky error/overflow flags and a coherent snapshot for GPIO readout. It also records non-NOP command cycles into a timestamped first-word-fall-through trace FIFO that the host drains through a pop strobe.

Parameters:
NUM_SLOTS, 4, command slots per fabric cycle (width of every ddr_* vector).
CNT_W, 16, width of each event counter and of the timestamp.
TAP_W, 8, number of low tdata bits captured as "latest handshake data".
TRACE_DEPTH, 16, trace FIFO entries; power of two, at least 2.
SATURATE, 0, counter overflow mode: 0 = wrap modulo 2^CNT_W, 1 = clamp at all-ones.

Ports:
clk  in  1  c0_ddr4_clk; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
clr  in  1  single-cycle soft clear from GPIO.
snap_req  in  1  single-cycle request to capture a snapshot.
axis_tvalid  in  1  C2H tvalid tap.
axis_tready  in  1  C2H tready tap.
axis_tdata_tap  in  TAP_W  C2H tdata[TAP_W-1:0].
rd_data_en  in  1  PHY rdDataEn.
err_in  in  1  sddt_core err.
ddr_read  in  NUM_SLOTS  per-slot READ flags.
ddr_write  in  NUM_SLOTS  per-slot WRITE flags.
ddr_pre  in  NUM_SLOTS  per-slot PRE flags.
ddr_nop  in  NUM_SLOTS  per-slot NOP flags.
snap_hs_cnt  out  CNT_W  snapshot of the handshake count.
snap_rden_cnt  out  CNT_W  snapshot of the read-enable count.
snap_rdcmd_cnt  out  CNT_W  snapshot of the READ command count.
snap_wrcmd_cnt  out  CNT_W  snapshot of the WRITE command count.
latest_hs_data  out  TAP_W  tdata tap at the last handshake.
err_sticky  out  1  err_in has been seen since reset or clear.
trace_valid  out  1  trace FIFO is non-empty.
trace_data  out  CNT_W+2*NUM_SLOTS  head entry, {timestamp, ddr_pre, ddr_nop}.
trace_pop  in  1  consume the head entry; ignored when the FIFO is empty.
trace_level  out  $clog2(TRACE_DEPTH)+1  current occupancy.
trace_overflow  out  1  sticky: at least one trace entry was dropped.

Behaviour:
- Reset (rst=1): all counters, snapshots, latest_hs_data, flags, the timestamp and the FIFO pointers/level go to 0. trace_valid=0.
- clr=1: same effect as reset on the next edge. Events presented in the same cycle as clr are discarded. rst and clr both take priority over snap_req and trace_pop.

Counters (live, internal):
- hs_cnt increments by 1 when tvalid&tready.
- rden_cnt increments by 1 when rd_data_en=1.
- rdcmd_cnt adds popcount(ddr_read), range 0..NUM_SLOTS.
- wrcmd_cnt adds popcount(ddr_write).
- Additions are performed at CNT_W+$clog2(NUM_SLOTS)+1 bits.
  - SATURATE=0: the result is truncated.
  - SATURATE=1: the result is clamped to 2^CNT_W-1 and stays there until clr.

Snapshot:
- When snap_req=1, every snap_* output loads the post-update live value, i.e. it includes the current cycle's events.
- Snapshot latency is 1 cycle. All four snapshot counters update on the same edge.

latest_hs_data:
- Loads axis_tdata_tap on every handshake (1-cycle latency).
- tvalid without tready has no effect.

err_sticky:
- Sets on err_in=1 and holds until rst or clr.

Timestamp:
- Free-running CNT_W counter that wraps. It is reset by rst or clr.

Trace push:
- A push occurs in any cycle where ddr_nop is not all-ones.
- The entry is {timestamp, ddr_pre, ddr_nop}, using that cycle's timestamp.

FIFO:
- First-word-fall-through: trace_data is the head whenever trace_valid=1, and is don't-care otherwise.
- Push into a non-full FIFO: accepted; the level increments unless a pop occurs in the same cycle.
- Push while full without a pop: the entry is dropped and trace_overflow sets (sticky until clr or rst).
- Push and pop in the same cycle while full: both succeed, the level stays at TRACE_DEPTH, no overflow.
- Pop and push in the same cycle while empty: the pop is ignored and the push is accepted.
- Pointers wrap modulo TRACE_DEPTH.

Decomposition:
- Shared package sddt_dbg_pkg holds:
  - the trace entry width function, CNT_W+2*NUM_SLOTS
  - a popcount function
  - the saturating-add function
- One sub-module, sddt_trace_fifo: a parametrised FWFT synchronous FIFO with push, pop, full, level and drop-flag logic.
- All counters, flags and snapshot logic stay in the top-level body.

Test Plan:
1. Reset, then 5 handshakes with tdata tap 0x11..0x15 interleaved with 3 tvalid-only cycles, then snap_req -> snap_hs_cnt=5, latest_hs_data=0x15.
2. ddr_read=4'b1011 for 3 cycles plus 4'b1111 for 1 cycle, then snap_req -> snap_rdcmd_cnt=13. Send snap_req in the same cycle as a 4'b0001 read -> snapshot=14.
3. SATURATE=1, CNT_W=4, 20 rd_data_en pulses -> snap_rden_cnt=15. With SATURATE=0 the same stimulus gives 4.
4. TRACE_DEPTH=4, 6 consecutive non-NOP cycles with no pops -> trace_level=4, trace_overflow=1, head timestamp equals the first push. Then pop 4 -> entries come out in order and trace_valid=0.
5. FIFO full, push and pop in the same cycle -> level stays 4, trace_overflow remains 0 (starting from a fresh state).
6. err_in pulse, then clr asserted in the same cycle as a handshake -> err_sticky=0, all counts 0, FIFO empty, and that handshake is not counted.
